// File: rtl/sar_track_ctrl.sv
// -----------------------------------------------------------------------------
// sar_track_ctrl
//
// Delay-line code controller for the FMDLL. The controller runs a WIDTH-bit
// successive-approximation search driven by the phase-detector comp bit. When
// tracking is built in, it then follows the phase with +/-1 code steps and
// flags lock after LOCK_CNT consecutive direction reversals.
//
// The binary code q_o drives the fine delay. Its top THERM_BITS bits are
// decoded into a thermometer bus for the coarse delay cells. Every cycle in
// which the code is loaded or changes, the controller pulses reset_pd_o so
// that the phase detector restarts its measurement.
//
// Build option:
//   TRACK_EN  When defined, the FSM enters TRK_WAIT/TRK_CMP after the SAR
//             search and locked_o is functional. When undefined, the FSM
//             parks in DONE holding the code, the tracking logic is not
//             built, and locked_o is tied to 0.
//
// Parameters:
//   WIDTH       code width (>= 2)
//   THERM_BITS  number of code MSBs decoded to thermometer (1..WIDTH)
//   SETTLE      cycles waited after each code change before comp is used (>= 1)
//   LOCK_CNT    consecutive tracking reversals that declare lock (>= 1)
//
// Ports:
//   clk_ext_i   controller clock; all flops use the rising edge
//   rst_i       asynchronous, active-high reset
//   start_i     begin or restart acquisition (level sampled; ignored while busy)
//   comp_i      PD result: 1 = code too low (keep bit / step up), 0 = too high
//   q_o         registered delay code
//   t_o         thermometer: t_o[k] = 1 iff k < q_o[WIDTH-1 -: THERM_BITS]
//   tb_o        ~t_o
//   reset_pd_o  1-cycle pulse for every cycle in which q_o is loaded or changed
//   busy_o      high while the SAR search is running
//   sar_done_o  high from the final SAR decision until restart or reset
//   locked_o    tracking lock flag
// -----------------------------------------------------------------------------
module sar_track_ctrl #(
    parameter int WIDTH      = 10,
    parameter int THERM_BITS = 4,
    parameter int SETTLE     = 3,
    parameter int LOCK_CNT   = 4
) (
    input  logic                       clk_ext_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       comp_i,
    output logic [WIDTH-1:0]           q_o,
    output logic [(2**THERM_BITS)-1:0] t_o,
    output logic [(2**THERM_BITS)-1:0] tb_o,
    output logic                       reset_pd_o,
    output logic                       busy_o,
    output logic                       sar_done_o,
    output logic                       locked_o
);

    localparam int THERM_N = 2**THERM_BITS;
    localparam int IDX_W   = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(SETTLE + 1);

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] Q_MID    = {1'b1, {(WIDTH-1){1'b0}}};

    // An illegal parameter set builds nothing extra; this named block makes
    // such a configuration visible in the elaborated hierarchy.
    if (WIDTH < 2 || THERM_BITS < 1 || THERM_BITS > WIDTH || SETTLE < 1 || LOCK_CNT < 1)
    begin : g_illegal_params
    end

`ifdef TRACK_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAR_WAIT = 3'd1,
        ST_SAR_CMP  = 3'd2,
        ST_DONE     = 3'd3,
        ST_TRK_WAIT = 3'd4,
        ST_TRK_CMP  = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAR_WAIT = 2'd1,
        ST_SAR_CMP  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_pd_q, reset_pd_d;
    logic             busy_q, busy_d;
    logic             sar_done_q, sar_done_d;
    logic             do_start;

`ifdef TRACK_EN
    localparam int               REV_W   = $clog2(LOCK_CNT + 1);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(LOCK_CNT);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             locked_q, locked_d;
    // dir_valid_q is clear until the first tracking step after a search, so
    // that step can never count as a reversal.
    logic             dir_valid_q, dir_valid_d;
    logic             dir_up_q, dir_up_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        reset_pd_d = 1'b0;
        sar_done_d = sar_done_q;
`ifdef TRACK_EN
        rev_d       = rev_q;
        locked_d    = locked_q;
        dir_valid_d = dir_valid_q;
        dir_up_d    = dir_up_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Leaving IDLE is handled by the start override below.
            end

            ST_SAR_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_SAR_CMP;
                end
            end

            ST_SAR_CMP: begin
                q_d[idx_q] = comp_i;
                if (idx_q != '0) begin
                    // Trial-set the next lower bit; it was 0, so the code
                    // always changes here.
                    q_d[idx_q - IDX_ONE] = 1'b1;
                    idx_d      = idx_q - IDX_ONE;
                    cnt_d      = CNT_LOAD;
                    reset_pd_d = 1'b1;
                    state_d    = ST_SAR_WAIT;
                end else begin
                    // The last decision only moves the code if bit 0 is cleared.
                    reset_pd_d = (q_d != q_q);
                    sar_done_d = 1'b1;
`ifdef TRACK_EN
                    cnt_d   = CNT_LOAD;
                    state_d = ST_TRK_WAIT;
`else
                    state_d = ST_DONE;
`endif
                end
            end

            ST_DONE: begin
                // Hold the code until start or reset.
            end

`ifdef TRACK_EN
            ST_TRK_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_TRK_CMP;
                end
            end

            ST_TRK_CMP: begin
                if (comp_i) begin
                    if (q_q != {WIDTH{1'b1}}) begin
                        q_d = q_q + WIDTH'(1);
                    end
                end else begin
                    if (q_q != '0) begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                reset_pd_d = (q_d != q_q);

                // The direction is recorded even when the step saturated.
                if (dir_valid_q && (dir_up_q != comp_i)) begin
                    if (rev_q != REV_MAX) begin
                        rev_d = rev_q + REV_ONE;
                    end
                    if (rev_d == REV_MAX) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    rev_d    = '0;
                    locked_d = 1'b0;
                end
                dir_valid_d = 1'b1;
                dir_up_d    = comp_i;

                cnt_d   = CNT_LOAD;
                state_d = ST_TRK_WAIT;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // start is honoured in every state outside the running search. It
        // overrides any tracking step taken in the same cycle.
        do_start = start_i && (state_q != ST_SAR_WAIT) && (state_q != ST_SAR_CMP);
        if (do_start) begin
            q_d        = Q_MID;
            idx_d      = IDX_TOP;
            cnt_d      = CNT_LOAD;
            reset_pd_d = 1'b1;
            sar_done_d = 1'b0;
            state_d    = ST_SAR_WAIT;
`ifdef TRACK_EN
            rev_d       = '0;
            locked_d    = 1'b0;
            dir_valid_d = 1'b0;
            dir_up_d    = 1'b0;
`endif
        end

        busy_d = (state_d == ST_SAR_WAIT) || (state_d == ST_SAR_CMP);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_ext_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            idx_q      <= IDX_TOP;
            cnt_q      <= '0;
            reset_pd_q <= 1'b0;
            busy_q     <= 1'b0;
            sar_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            reset_pd_q <= reset_pd_d;
            busy_q     <= busy_d;
            sar_done_q <= sar_done_d;
        end
    end

`ifdef TRACK_EN
    always_ff @(posedge clk_ext_i or posedge rst_i) begin
        if (rst_i) begin
            rev_q       <= '0;
            locked_q    <= 1'b0;
            dir_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
        end else begin
            rev_q       <= rev_d;
            locked_q    <= locked_d;
            dir_valid_q <= dir_valid_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign locked_o = locked_q;
`else
    assign locked_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q_o        = q_q;
    assign reset_pd_o = reset_pd_q;
    assign busy_o     = busy_q;
    assign sar_done_o = sar_done_q;

    // The thermometer is decoded straight from the code register, so it
    // changes in the same cycle as q_o.
    logic [THERM_BITS-1:0] q_top;
    assign q_top = q_q[WIDTH-1 -: THERM_BITS];

    for (genvar gi = 0; gi < THERM_N; gi++) begin : g_therm
        localparam logic [THERM_BITS-1:0] K = THERM_BITS'(gi);
        assign t_o[gi] = (K < q_top);
    end

    assign tb_o = ~t_o;

endmodule

// File: tb/tb_sar_track_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_track_ctrl
//
// Self-checking bench for sar_track_ctrl with WIDTH=10, THERM_BITS=4,
// SETTLE=2, LOCK_CNT=4. The phase detector is modelled as
// comp = (q <= target). The expected SAR result is the target clamped to the
// code range, and tracking is predicted by a step-level integer model.
// -----------------------------------------------------------------------------
module tb_sar_track_ctrl;

    localparam int W     = 10;
    localparam int TBITS = 4;
    localparam int S     = 2;
    localparam int L     = 4;
    localparam int NT    = 16;
    localparam int QMAX  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          comp;
    logic [W-1:0]  q;
    logic [NT-1:0] t;
    logic [NT-1:0] tbar;
    logic          reset_pd;
    logic          busy;
    logic          sar_done;
    logic          locked;

    logic comp_force_en  = 1'b0;
    logic comp_force_val = 1'b0;
    int   target = 0;

    int n_vec = 0;
    int n_bad = 0;

    // Tracking model state
    int m_q   = 0;
    int m_rev = 0;
    bit m_valid = 1'b0;
    bit m_up    = 1'b0;
    bit m_lk    = 1'b0;

    always #5 clk = ~clk;

    always_comb comp = comp_force_en ? comp_force_val : (int'(q) <= target);

    sar_track_ctrl #(
        .WIDTH(W),
        .THERM_BITS(TBITS),
        .SETTLE(S),
        .LOCK_CNT(L)
    ) dut (
        .clk_ext_i (clk),
        .rst_i     (rst),
        .start_i   (start),
        .comp_i    (comp),
        .q_o       (q),
        .t_o       (t),
        .tb_o      (tbar),
        .reset_pd_o(reset_pd),
        .busy_o    (busy),
        .sar_done_o(sar_done),
        .locked_o  (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sar_expect(input int tgt);
        if (tgt < 0)    return 0;
        if (tgt > QMAX) return QMAX;
        return tgt;
    endfunction

    function automatic logic [NT-1:0] therm_of(input int code);
        logic [NT-1:0] r;
        int top;
        top = code >> (W - TBITS);
        r = '0;
        for (int k = 0; k < NT; k++) begin
            if (k < top) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Launches a search (start sampled on the next edge, called edge 0),
    // follows it for W*(S+1) edges and checks the outcome.
    task automatic run_sar(input int tgt, input bit inject);
        int expq, last, pulses, first_done, busy_cnt, exp_pulses;
        logic [W-1:0]  eq;
        logic [NT-1:0] et;
        expq = sar_expect(tgt);
        eq   = W'(expq);
        et   = therm_of(expq);
        last = W * (S + 1);
        target = tgt;

        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (q !== 10'h200 || reset_pd !== 1'b1 || busy !== 1'b1 || sar_done !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL sar_launch: q=%h reset_pd=%b busy=%b sar_done=%b locked=%b, required q=200 reset_pd=1 busy=1 sar_done=0 locked=0",
                     q, reset_pd, busy, sar_done, locked);
        end

        pulses = 1;
        first_done = -1;
        busy_cnt = 0;
        for (int e = 1; e <= last; e++) begin
            if (inject && (e % 7) == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (reset_pd === 1'b1) pulses++;
            if (busy === 1'b1) busy_cnt++;
            if (sar_done === 1'b1 && first_done < 0) first_done = e;
        end

        exp_pulses = W + (((expq % 2) == 0) ? 1 : 0);
        n_vec++;
        if (first_done != last) begin
            n_bad++;
            $display("FAIL sar_done_edge: rose after edge %0d, required %0d (target %0d)", first_done, last, tgt);
        end
        n_vec++;
        if (busy_cnt != last - 1) begin
            n_bad++;
            $display("FAIL busy_length: busy high on %0d edges, required %0d", busy_cnt, last - 1);
        end
        n_vec++;
        if (q !== eq) begin
            n_bad++;
            $display("FAIL sar_code: q=%h, required %h (target %0d)", q, eq, tgt);
        end
        n_vec++;
        if (t !== et || tbar !== ~et) begin
            n_bad++;
            $display("FAIL therm: t=%h tb=%h, required t=%h tb=%h", t, tbar, et, ~et);
        end
        n_vec++;
        if (pulses != exp_pulses) begin
            n_bad++;
            $display("FAIL reset_pd_count: %0d pulses, required %0d", pulses, exp_pulses);
        end
        $display("sar target=%0d q=%h t=%h pulses=%0d done_edge=%0d", tgt, q, t, pulses, first_done);

        m_q = expq;
        m_rev = 0;
        m_valid = 1'b0;
        m_up = 1'b0;
        m_lk = 1'b0;
    endtask

`ifdef TRACK_EN
    // Each tracking step is S wait edges followed by one compare edge.
    task automatic track_steps(input int nsteps);
        bit c, chg;
        int nq;
        for (int i = 0; i < nsteps; i++) begin
            for (int w = 0; w < S; w++) tick();
            c = (m_q <= target);
            if (c) nq = (m_q < QMAX) ? m_q + 1 : m_q;
            else   nq = (m_q > 0) ? m_q - 1 : m_q;
            chg = (nq != m_q);
            if (m_valid && (m_up != c)) begin
                if (m_rev < L) m_rev++;
                if (m_rev == L) m_lk = 1'b1;
            end else begin
                m_rev = 0;
                m_lk = 1'b0;
            end
            m_valid = 1'b1;
            m_up = c;
            m_q = nq;
            tick();
            n_vec++;
            if (q !== W'(m_q) || locked !== m_lk || reset_pd !== chg) begin
                n_bad++;
                $display("FAIL track_step: q=%h locked=%b reset_pd=%b, required q=%h locked=%b reset_pd=%b",
                         q, locked, reset_pd, W'(m_q), m_lk, chg);
            end
            $display("track target=%0d q=%h locked=%b reset_pd=%b", target, q, locked, reset_pd);
        end
    endtask
`endif

    task automatic test_reset();
        #1;
        n_vec++;
        if (q !== 10'h000 || t !== 16'h0000 || tbar !== 16'hFFFF || busy !== 1'b0 ||
            sar_done !== 1'b0 || reset_pd !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_initial: q=%h t=%h tb=%h busy=%b sar_done=%b reset_pd=%b locked=%b, required 000 0000 ffff 0 0 0 0",
                     q, t, tbar, busy, sar_done, reset_pd, locked);
        end
        tick();
        tick();
        rst = 1'b0;
        target = 300;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midsearch_busy: busy=%b, required 1", busy);
        end
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if (q !== 10'h000 || t !== 16'h0000 || tbar !== 16'hFFFF || busy !== 1'b0 ||
            sar_done !== 1'b0 || reset_pd !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: q=%h t=%h tb=%h busy=%b sar_done=%b reset_pd=%b locked=%b, required 000 0000 ffff 0 0 0 0",
                     q, t, tbar, busy, sar_done, reset_pd, locked);
        end
        #2 rst = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (q !== 10'h000 || busy !== 1'b0 || sar_done !== 1'b0 || reset_pd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: q=%h busy=%b sar_done=%b reset_pd=%b, required 000 0 0 0",
                     q, busy, sar_done, reset_pd);
        end
        $display("reset q=%h t=%h tb=%h busy=%b", q, t, tbar, busy);
    endtask

    task automatic test_sar_basic();
        run_sar(12'h2A5, 1'b1);
        n_vec++;
        if (q !== 10'h2A5 || t !== 16'h03FF || tbar !== 16'hFC00) begin
            n_bad++;
            $display("FAIL sar_basic: q=%h t=%h tb=%h, required 2a5 03ff fc00", q, t, tbar);
        end
    endtask

    task automatic test_rails();
        run_sar(QMAX, 1'b0);
`ifdef TRACK_EN
        track_steps(5);
        n_vec++;
        if (locked !== 1'b0 || q !== 10'h3FF) begin
            n_bad++;
            $display("FAIL rail_high_track: q=%h locked=%b, required 3ff 0", q, locked);
        end
`endif
        run_sar(-1, 1'b0);
`ifdef TRACK_EN
        track_steps(5);
        n_vec++;
        if (locked !== 1'b0 || q !== 10'h000) begin
            n_bad++;
            $display("FAIL rail_low_track: q=%h locked=%b, required 000 0", q, locked);
        end
`endif
    endtask

`ifdef TRACK_EN
    task automatic test_track_lock();
        run_sar(12'h2A5, 1'b0);
        track_steps(8);
        n_vec++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL track_lock: locked=%b, required 1", locked);
        end
        target = 12'h2B0;
        track_steps(30);
        n_vec++;
        if (locked !== 1'b1 || (q !== 10'h2B0 && q !== 10'h2B1)) begin
            n_bad++;
            $display("FAIL track_relock: q=%h locked=%b, required q in 2b0..2b1 locked=1", q, locked);
        end
    endtask
`else
    task automatic test_done_hold();
        int bad, pulses;
        logic [W-1:0] eq;
        bad = 0;
        pulses = 0;
        run_sar(int'($urandom_range(0, QMAX)), 1'b0);
        eq = W'(m_q);
        comp_force_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            comp_force_val = 1'($urandom_range(0, 1));
            tick();
            if (q !== eq || locked !== 1'b0 || sar_done !== 1'b1 || busy !== 1'b0) bad++;
            if (reset_pd !== 1'b0) pulses++;
        end
        comp_force_en = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL done_hold: %0d bad cycles, last q=%h locked=%b sar_done=%b, required q=%h locked=0 sar_done=1",
                     bad, q, locked, sar_done, eq);
        end
        n_vec++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL done_reset_pd: %0d pulses, required 0", pulses);
        end
        $display("done_hold q=%h bad=%0d pulses=%0d", q, bad, pulses);
    endtask
`endif

    task automatic test_restart();
        run_sar(12'h2A5, 1'b0);
`ifdef TRACK_EN
        track_steps(6);
        n_vec++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_prelock: locked=%b, required 1", locked);
        end
        // Two wait edges, so the restart coincides with a compare edge.
        tick();
        tick();
`else
        repeat (20) tick();
        n_vec++;
        if (sar_done !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_predone: sar_done=%b, required 1", sar_done);
        end
`endif
        run_sar(int'($urandom_range(0, QMAX)), 1'b1);
    endtask

    task automatic test_random();
        int tgt;
        bit inj;
        for (int i = 0; i < 6; i++) begin
            tgt = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, QMAX));
            inj = 1'($urandom_range(0, 1));
            run_sar(tgt, inj);
`ifdef TRACK_EN
            track_steps(int'($urandom_range(1, 6)));
`endif
            repeat ($urandom_range(0, 4)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_sar_basic();
        test_rails();
`ifdef TRACK_EN
        test_track_lock();
`else
        test_done_hold();
`endif
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
